// File: rtl/rf_writeback_arbiter_if.sv
// rtl/rf_writeback_arbiter_if.sv - valid/ready writeback request channel (rd, wd) for one requester
interface rf_writeback_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) ();
  logic                  valid;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] wd;
  logic                  ready;

  modport master (output valid, output rd, output wd, input ready);
  modport slave  (input valid, input rd, input wd, output ready);
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - shares the RF write port between ALU and MEM writeback; optional RF_WB_BYPASS_EN forwarding
module rf_writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ARB_MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  rf_writeback_arbiter_if.slave      alu,
  rf_writeback_arbiter_if.slave      mem,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_rd,
  output logic                       rf_we,
  output logic [ADDR_WIDTH-1:0]      rf_wa,
  output logic [DATA_WIDTH-1:0]      rf_wd,
`ifdef RF_WB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0]      byp_a1,
  input  logic [ADDR_WIDTH-1:0]      byp_a2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [DATA_WIDTH-1:0]      byp_d1,
  output logic [DATA_WIDTH-1:0]      byp_d2,
`endif
  output logic [(2**ADDR_WIDTH)-1:0] pending
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic            last_mem;   // 1 = MEM was granted most recently
  logic            alu_nz;
  logic            mem_nz;
  logic            grant_alu;
  logic            grant_mem;
  logic [NREG-1:0] pending_nxt;

  // x0 requests never compete: they are accepted and discarded
  assign alu_nz = alu.valid && (alu.rd != '0);
  assign mem_nz = mem.valid && (mem.rd != '0);

  // MEM wins when alone, under fixed priority, or when ALU held the last grant
  assign grant_mem = mem_nz && (!alu_nz || (ARB_MODE == 1) || !last_mem);
  assign grant_alu = alu_nz && !grant_mem;

  assign alu.ready = alu.valid && ((alu.rd == '0) || grant_alu);
  assign mem.ready = mem.valid && ((mem.rd == '0) || grant_mem);

  // Round-robin pointer follows every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_mem <= 1'b0;
    end else if (grant_mem) begin
      last_mem <= 1'b1;
    end else if (grant_alu) begin
      last_mem <= 1'b0;
    end
  end

  // Register the winning write; address/data hold when there is no grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= grant_mem || grant_alu;
      if (grant_mem) begin
        rf_wa <= mem.rd;
        rf_wd <= mem.wd;
      end else if (grant_alu) begin
        rf_wa <= alu.rd;
        rf_wd <= alu.wd;
      end
    end
  end

  // Scoreboard update: clear on MEM writeback, then set on issue so a new issue wins
  always_comb begin
    pending_nxt = pending;
    if (grant_mem) begin
      pending_nxt[mem.rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pending_nxt[iss_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Forward the write committing this cycle to same-cycle readers
  assign byp_hit1 = rf_we && (rf_wa == byp_a1) && (byp_a1 != '0);
  assign byp_hit2 = rf_we && (rf_wa == byp_a2) && (byp_a2 != '0);
  assign byp_d1   = rf_wd;
  assign byp_d2   = rf_wd;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - directed bench for rf_writeback_arbiter, round-robin and fixed-priority instances
module tb_rf_writeback_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iss_valid = 1'b0;
  logic [AW-1:0] iss_rd = '0;

  logic          rf_we0, rf_we1;
  logic [AW-1:0] rf_wa0, rf_wa1;
  logic [DW-1:0] rf_wd0, rf_wd1;
  logic [31:0]   pending0, pending1;

`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0] byp_a1 = '0;
  logic [AW-1:0] byp_a2 = '0;
  logic          byp_hit1_0, byp_hit2_0, byp_hit1_1, byp_hit2_1;
  logic [DW-1:0] byp_d1_0, byp_d2_0, byp_d1_1, byp_d2_1;
`endif

  int vectors = 0;
  int miscompares = 0;

  rf_writeback_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a0 ();
  rf_writeback_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0 ();
  rf_writeback_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
  rf_writeback_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1 ();

  rf_writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .alu(a0), .mem(m0),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(rf_we0), .rf_wa(rf_wa0), .rf_wd(rf_wd0),
`ifdef RF_WB_BYPASS_EN
    .byp_a1(byp_a1), .byp_a2(byp_a2), .byp_hit1(byp_hit1_0), .byp_hit2(byp_hit2_0),
    .byp_d1(byp_d1_0), .byp_d2(byp_d2_0),
`endif
    .pending(pending0)
  );

  rf_writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .alu(a1), .mem(m1),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(rf_we1), .rf_wa(rf_wa1), .rf_wd(rf_wd1),
`ifdef RF_WB_BYPASS_EN
    .byp_a1(byp_a1), .byp_a2(byp_a2), .byp_hit1(byp_hit1_1), .byp_hit2(byp_hit2_1),
    .byp_d1(byp_d1_1), .byp_d2(byp_d2_1),
`endif
    .pending(pending1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] awd,
                       input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mwd);
    a0.valid = av; a0.rd = ard; a0.wd = awd;
    a1.valid = av; a1.rd = ard; a1.wd = awd;
    m0.valid = mv; m0.rd = mrd; m0.wd = mwd;
    m1.valid = mv; m1.rd = mrd; m1.wd = mwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with both requesters valid
    drive(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB);
    tick(); tick(); tick();
    chk("rst_we0", rf_we0, 0);
    chk("rst_we1", rf_we1, 0);
    chk("rst_wa0", rf_wa0, 0);
    chk("rst_wd0", rf_wd0, 0);
    chk("rst_pend0", pending0, 0);
    chk("rst_pend1", pending1, 0);

    // Release: MEM wins the first tie in both modes
    rst_n = 1'b1;
    #1;
    chk("c0_mrdy0", m0.ready, 1);
    chk("c0_ardy0", a0.ready, 0);
    chk("c0_mrdy1", m1.ready, 1);
    chk("c0_ardy1", a1.ready, 0);
    tick();
    chk("c0_we0", rf_we0, 1);
    chk("c0_wa0", rf_wa0, 6);
    chk("c0_wd0", rf_wd0, 32'hBBBB);
    chk("c0_wa1", rf_wa1, 6);
    // Second contended cycle: round-robin flips to ALU, fixed priority stays MEM
    chk("c1_ardy0", a0.ready, 1);
    chk("c1_mrdy0", m0.ready, 0);
    chk("c1_mrdy1", m1.ready, 1);
    chk("c1_ardy1", a1.ready, 0);
    tick();
    chk("c1_wa0", rf_wa0, 5);
    chk("c1_wd0", rf_wd0, 32'hAAAA);
    chk("c1_wa1", rf_wa1, 6);
    chk("c2_mrdy0", m0.ready, 1);
    chk("c2_mrdy1", m1.ready, 1);
    chk("c2_ardy1", a1.ready, 0);
    tick();
    chk("c2_wa0", rf_wa0, 6);
    chk("c2_wa1", rf_wa1, 6);

    // MEM drops: ALU granted in both modes
    drive(1'b1, 5'd5, 32'hAAAA, 1'b0, 5'd6, 32'hBBBB);
    #1;
    chk("c3_ardy0", a0.ready, 1);
    chk("c3_ardy1", a1.ready, 1);
    tick();
    chk("c3_wa1", rf_wa1, 5);
    chk("c3_wd1", rf_wd1, 32'hAAAA);
    chk("c3_we1", rf_we1, 1);

    // Idle cycle: no write, address/data hold
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("idle_we0", rf_we0, 0);
    chk("idle_wa0", rf_wa0, 5);
    chk("idle_wd0", rf_wd0, 32'hAAAA);

    // x0 bypasses arbitration alongside a MEM write
    drive(1'b1, 5'd0, 32'h1111, 1'b1, 5'd7, 32'h7777);
    #1;
    chk("x0_ardy0", a0.ready, 1);
    chk("x0_mrdy0", m0.ready, 1);
    chk("x0_ardy1", a1.ready, 1);
    chk("x0_mrdy1", m1.ready, 1);
    tick();
    chk("x0_we0", rf_we0, 1);
    chk("x0_wa0", rf_wa0, 7);
    chk("x0_wd0", rf_wd0, 32'h7777);
    drive(1'b1, 5'd0, 32'h2222, 1'b0, 5'd0, 32'h0);
    #1;
    chk("x0only_ardy0", a0.ready, 1);
    tick();
    chk("x0only_we0", rf_we0, 0);
    chk("x0only_wa0", rf_wa0, 7);

    // Scoreboard set, x0 issue ignored, clear on MEM writeback
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    chk("sb_set9_0", pending0, 32'h0000_0200);
    chk("sb_set9_1", pending1, 32'h0000_0200);
    iss_rd = 5'd0;
    tick();
    chk("sb_iss0", pending0, 32'h0000_0200);
    iss_valid = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999);
    tick();
    chk("sb_clr9_0", pending0, 0);
    chk("sb_clr9_1", pending1, 0);
    chk("sb_clr9_wa", rf_wa0, 9);
    // Re-issue then same-edge set and clear: set wins
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    chk("sb_reset9", pending0, 32'h0000_0200);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9A9A);
    tick();
    chk("sb_setwins0", pending0, 32'h0000_0200);
    chk("sb_setwins1", pending1, 32'h0000_0200);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    iss_rd = 5'd12;
    tick();
    chk("sb_two", pending0, 32'h0000_1200);
    iss_valid = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hCCCC);
    tick();
    chk("sb_clr12", pending0, 32'h0000_0200);
    chk("sb_clr12_we", rf_we0, 1);

    // Asynchronous reset mid-operation drops the in-flight write and the scoreboard
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4444);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we0", rf_we0, 0);
    chk("arst_wa0", rf_wa0, 0);
    chk("arst_pend0", pending0, 0);
    chk("arst_pend1", pending1, 0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_noreplay", rf_we0, 0);

    // Pointer back at ALU after reset: MEM wins the tie again
    drive(1'b1, 5'd3, 32'h1234, 1'b1, 5'd8, 32'h8888);
    #1;
    chk("rst2_mrdy0", m0.ready, 1);
    chk("rst2_ardy0", a0.ready, 0);
    tick();
    drive(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'h0);
    tick();
    chk("w3_wa0", rf_wa0, 3);
    chk("w3_wd0", rf_wd0, 32'h1234);
`ifdef RF_WB_BYPASS_EN
    byp_a1 = 5'd3; byp_a2 = 5'd0;
    #1;
    chk("byp_hit1", byp_hit1_0, 1);
    chk("byp_d1", byp_d1_0, 32'h1234);
    chk("byp_hit2", byp_hit2_0, 0);
    byp_a1 = 5'd4;
    #1;
    chk("byp_miss1", byp_hit1_0, 0);
`endif
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
